// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch FSM, one-entry skid buffer
// and the IF/ID pipeline register.
module fetch_stage #(
  parameter int unsigned          REGISTER_BITS = 5,
  parameter int unsigned          ADDR_BITS     = 32,
  parameter int unsigned          INSTR_BITS    = 32,
  parameter logic [ADDR_BITS-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Hold,
  input  logic                     branch_taken,
  input  logic [ADDR_BITS-1:0]     branch_target,
  output logic                     imem_req,
  output logic [ADDR_BITS-1:0]     imem_addr,
  input  logic [INSTR_BITS-1:0]    imem_rdata,
  input  logic                     imem_ready,
  output logic [ADDR_BITS-1:0]     IF_ID_PC,
  output logic [INSTR_BITS-1:0]    IF_ID_Instr,
  output logic                     IF_ID_Valid,
  output logic [REGISTER_BITS-1:0] IF_ID_RS,
  output logic [REGISTER_BITS-1:0] IF_ID_RT,
  output logic                     fetch_stall
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_HELD
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_BITS-1:0]    pc_q, pc_d;
  logic [ADDR_BITS-1:0]    ifid_pc_q, ifid_pc_d;
  logic [INSTR_BITS-1:0]   ifid_instr_q, ifid_instr_d;
  logic                    ifid_valid_q, ifid_valid_d;
  logic [INSTR_BITS-1:0]   skid_q, skid_d;

  logic [ADDR_BITS-1:0]    pc_inc;

  assign pc_inc      = pc_q + ADDR_BITS'(4);
  assign imem_addr   = pc_q;
  assign IF_ID_PC    = ifid_pc_q;
  assign IF_ID_Instr = ifid_instr_q;
  assign IF_ID_Valid = ifid_valid_q;
  assign IF_ID_RS    = ifid_instr_q[21 +: REGISTER_BITS];
  assign IF_ID_RT    = ifid_instr_q[16 +: REGISTER_BITS];

  // Next-state, PC, IF/ID and skid-buffer selection; priority is branch > Hold > imem_ready.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    skid_d       = skid_q;
    imem_req     = 1'b0;
    fetch_stall  = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req    = 1'b1;
        fetch_stall = ~imem_ready;
        if (branch_taken) begin
          pc_d         = branch_target;
          ifid_pc_d    = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
          skid_d       = '0;
          state_d      = S_FETCH;
        end else if (Hold) begin
          // A word returned while held is parked so it is not refetched or lost.
          if (imem_ready) begin
            skid_d  = imem_rdata;
            state_d = S_HELD;
          end
        end else if (imem_ready) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = imem_rdata;
          ifid_valid_d = 1'b1;
          pc_d         = pc_inc;
        end else begin
          ifid_pc_d    = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
        end
      end

      S_HELD: begin
        if (branch_taken) begin
          pc_d         = branch_target;
          ifid_pc_d    = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
          skid_d       = '0;
          state_d      = S_FETCH;
        end else if (!Hold) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = skid_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_inc;
          state_d      = S_FETCH;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase

    if (rst) begin
      imem_req    = 1'b0;
      fetch_stall = 1'b0;
    end
  end

  // State, PC, IF/ID and skid registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: expected IF/ID contents are queued
// as each fetch is driven and popped when the instruction should appear.
module tb_fetch_stage;

  localparam int unsigned   AW  = 32;
  localparam int unsigned   IW  = 32;
  localparam int unsigned   RW  = 5;
  localparam logic [AW-1:0] RPC = '0;

  localparam int E_KEEP = 0;
  localparam int E_LOAD = 1;
  localparam int E_BUB  = 2;
  localparam int E_RST  = 3;

  logic          clk = 1'b0;
  logic          rst, Hold, branch_taken;
  logic [AW-1:0] branch_target;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          imem_ready;
  logic [AW-1:0] IF_ID_PC;
  logic [IW-1:0] IF_ID_Instr;
  logic          IF_ID_Valid;
  logic [RW-1:0] IF_ID_RS, IF_ID_RT;
  logic          fetch_stall;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } exp_t;

  exp_t          sb_q[$];
  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  logic [AW-1:0] exp_pc;

  fetch_stage #(
    .REGISTER_BITS(RW),
    .ADDR_BITS    (AW),
    .INSTR_BITS   (IW),
    .RESET_PC     (RPC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Hold         (Hold),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .IF_ID_PC     (IF_ID_PC),
    .IF_ID_Instr  (IF_ID_Instr),
    .IF_ID_Valid  (IF_ID_Valid),
    .IF_ID_RS     (IF_ID_RS),
    .IF_ID_RT     (IF_ID_RT),
    .fetch_stall  (fetch_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  // Memory model: address-derived word when ready, poison otherwise.
  always_comb imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check request-side outputs, then the IF/ID effect.
  task automatic cyc(input logic r, input logic h, input logic b, input logic [AW-1:0] tgt,
                     input logic rdy, input logic exp_req, input logic exp_stall, input int eff);
    exp_t          e;
    logic [AW-1:0] s_pc;
    logic [IW-1:0] s_in;
    logic          s_v;
    rst = r; Hold = h; branch_taken = b; branch_target = tgt; imem_ready = rdy;
    #1;
    check("imem_req", imem_req, exp_req);
    check("fetch_stall", fetch_stall, exp_stall);
    if (!r) check("imem_addr", imem_addr, exp_pc);
    s_pc = IF_ID_PC; s_in = IF_ID_Instr; s_v = IF_ID_Valid;
    if (eff == E_LOAD) begin
      sb_q.push_back(exp_t'{exp_pc, mem_word(exp_pc)});
      exp_pc = exp_pc + 32'd4;
    end else if (eff == E_BUB && b) begin
      exp_pc = tgt;
    end else if (eff == E_RST) begin
      exp_pc = RPC;
    end
    @(posedge clk);
    #1;
    if (eff == E_LOAD) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1'b1, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("ifid_pc", IF_ID_PC, e.pc);
        check("ifid_instr", IF_ID_Instr, e.instr);
        check("ifid_valid", IF_ID_Valid, 1'b1);
        check("ifid_rs", IF_ID_RS, e.instr[25:21]);
        check("ifid_rt", IF_ID_RT, e.instr[20:16]);
      end
    end else if (eff == E_KEEP) begin
      check("keep_pc", IF_ID_PC, s_pc);
      check("keep_instr", IF_ID_Instr, s_in);
      check("keep_valid", IF_ID_Valid, s_v);
    end else begin
      check("bub_pc", IF_ID_PC, '0);
      check("bub_instr", IF_ID_Instr, '0);
      check("bub_valid", IF_ID_Valid, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; Hold = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    imem_ready = 1'b1; exp_pc = RPC;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", IF_ID_Valid, 1'b0);
    check("rst_pc", IF_ID_PC, '0);
    check("rst_instr", IF_ID_Instr, '0);
    check("rst_req", imem_req, 1'b0);
    check("rst_stall", fetch_stall, 1'b0);
    check("rst_addr", imem_addr, RPC);

    // Boot cycle: branch ignored, no request, no stall.
    cyc(0, 0, 1, 32'h40, 0, 0, 0, E_KEEP);
    cyc(0, 0, 0, '0, 1, 1, 0, E_LOAD);           // PC 0
    cyc(0, 0, 0, '0, 1, 1, 0, E_LOAD);           // PC 4
    // Hold for three cycles at PC 8.
    cyc(0, 1, 0, '0, 1, 1, 0, E_KEEP);
    cyc(0, 1, 0, '0, 0, 0, 0, E_KEEP);
    cyc(0, 1, 0, '0, 0, 0, 0, E_KEEP);
    cyc(0, 0, 0, '0, 0, 0, 0, E_LOAD);           // PC 8 from skid
    cyc(0, 0, 0, '0, 1, 1, 0, E_LOAD);           // PC 12
    // Memory not ready at PC 16.
    cyc(0, 0, 0, '0, 0, 1, 1, E_BUB);
    cyc(0, 0, 0, '0, 0, 1, 1, E_BUB);
    cyc(0, 0, 0, '0, 1, 1, 0, E_LOAD);           // PC 16
    cyc(0, 1, 0, '0, 0, 1, 1, E_KEEP);           // held while not ready
    cyc(0, 0, 0, '0, 1, 1, 0, E_LOAD);           // PC 20
    // Branch out of the held state discards the skid word.
    cyc(0, 1, 0, '0, 1, 1, 0, E_KEEP);           // PC 24 -> held
    cyc(0, 1, 1, 32'h100, 0, 0, 0, E_BUB);
    cyc(0, 0, 0, '0, 1, 1, 0, E_LOAD);           // PC 0x100
    // Branch in fetch beats a ready response; then address wrap.
    cyc(0, 0, 1, 32'hFFFF_FFF8, 1, 1, 0, E_BUB);
    cyc(0, 0, 0, '0, 1, 1, 0, E_LOAD);           // 0xFFFFFFF8
    cyc(0, 0, 0, '0, 1, 1, 0, E_LOAD);           // 0xFFFFFFFC
    cyc(0, 0, 0, '0, 1, 1, 0, E_LOAD);           // 0x0 after wrap
    // Branch beats Hold while memory is stalled.
    cyc(0, 1, 1, 32'h200, 0, 1, 1, E_BUB);
    cyc(0, 0, 0, '0, 1, 1, 0, E_LOAD);           // 0x200
    // Reset during held state with a branch pending.
    cyc(0, 1, 0, '0, 1, 1, 0, E_KEEP);           // 0x204 -> held
    cyc(1, 1, 1, 32'h300, 0, 0, 0, E_RST);
    cyc(0, 0, 0, '0, 1, 0, 0, E_KEEP);           // boot
    cyc(0, 0, 0, '0, 1, 1, 0, E_LOAD);           // RESET_PC
    check("sb_drain", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
